array_wr_arbiter: RTL and testbench
===================================

# array_wr_arbiter

Shares a single unpacked register array between NUM_REQ write requesters using round-robin arbitration, one write committed per cycle. Adds a registered read port with write bypass and exposes the whole array as an unpacked output. It sits in front of the array-typed storage used by our unpacked-array datapath cases as the controller that serialises concurrent writers.

## Interface

Parameters:
- NUM_REQ, 4, number of write requesters (≥2)
- DEPTH, 4, entries in the shared array (≥2, any value)
- WIDTH, 8, bits per entry
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid[NUM_REQ]  in  1 each  requester i has a write pending
- req_addr[NUM_REQ]  in  ADDR_W each  target entry
- req_data[NUM_REQ]  in  WIDTH each  write data
- req_ready[NUM_REQ]  out  1 each  combinational accept, at most one bit set
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data valid, one-cycle pulse
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester (registered)
- oob_err  out  1  registered pulse: accepted write had req_addr ≥ DEPTH
- mem_o[DEPTH]  out  WIDTH each  current array contents

## Operation

- Round-robin pointer ptr selects the requester. The winner is the first i with req_valid[i], scanning ptr, ptr+1, … modulo NUM_REQ.
- Winner k gets req_ready[k]=1 in the same cycle. The transfer occurs when valid and ready are both high.
- On transfer: ptr ← (k+1) mod NUM_REQ; grant_id ← k. With no transfer, ptr and grant_id hold.
- Accepted write enters the stage register (st_v, st_addr, st_data). On the next cycle the stage commits: mem[st_addr] ← st_data.
- Out-of-range address: the write is accepted (ready asserted) but dropped. st_v stays 0 and oob_err pulses the cycle after acceptance.
- Read: rd_en in cycle t gives rd_data and rd_valid=1 after the edge ending t.
  - rd_data = mem[rd_addr] as of the start of t.
  - Bypass: if the stage commits to rd_addr in cycle t, rd_data = st_data.
  - rd_addr ≥ DEPTH returns 0.
- mem_o mirrors mem and shows the commit after the edge.
- While rst is high, req_ready is forced to all zeros.

## Timing

- Reset (edge with rst=1) sets:
  - every mem entry, mem_o, rd_data: 0
  - rd_valid, oob_err, st_v: 0
  - grant_id, ptr: 0
- Write latency: accept in cycle t, stage valid in t+1, mem_o updated after the edge ending t+1 (2 edges).
- Throughput: one accepted write per cycle, sustained with no bubbles.
- Same address accepted in back-to-back cycles: commits occur in acceptance order, so the later write wins.
- Read and commit to the same address in the same cycle: the bypass value is returned.
- Reset asserted with st_v=1: the pending write is discarded and never reaches mem.
- All requesters valid continuously: grants rotate 0,1,2,3,0,…. No requester waits more than NUM_REQ−1 cycles.
- req_valid may drop without a transfer; the arbiter holds no state for ungranted requests.

## Structure

- Package array_arb_pkg holds:
  - localparam defaults (NUM_REQ, DEPTH, WIDTH)
  - typedef req_idx_t for the requester index
  - function next_ptr(k) for modulo wrap
- One sub-module, rr_pick: purely combinational, taking req_valid[] and ptr and producing a one-hot grant[], a found flag and winner index.
- The top holds ptr, the stage register, the mem array and the read register, all in one clocked always block with a synchronous reset branch.

## Test plan

- Reset then idle:
  - mem_o all 0, rd_valid=0, grant_id=0, req_ready all 0 while rst=1
  - rd_en with rd_addr=2 → rd_data=0 next cycle
- All four requesters valid for 8 cycles, req_addr[i]=i, req_data[i]=8'hA0+i:
  - ready pattern 0,1,2,3,0,1,2,3
  - mem_o = {A3,A2,A1,A0} two edges after the last first-round accept
- Requesters 1 and 3 valid, ptr=2 → req_ready[3]=1 first, then req_ready[1] (wrap-around).
- Write 8'h5C to addr 1, with rd_en on addr 1 in the commit cycle → rd_data=8'h5C via bypass. A read one cycle earlier returns the old value 0.
- DEPTH=3, requester 0 writes addr 3 → accepted, oob_err=1 one cycle later, mem_o unchanged.
- Accept a write, assert rst in the next cycle → mem_o stays all 0 and st_v=0 after reset.

Source files
------------

// File: rtl/array_arb_pkg.sv
// Shared defaults, index type and pointer arithmetic for the array write arbiter.
package array_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DEPTH_DEF   = 4;
    localparam int WIDTH_DEF   = 8;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;

    // Round-robin successor of k among n requesters, wrapping to zero.
    function automatic int unsigned next_ptr(input int unsigned k, input int unsigned n);
        return (k + 32'd1 >= n) ? 32'd0 : k + 32'd1;
    endfunction

endpackage

// File: rtl/array_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_pick
    import array_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic             req_valid [NUM_REQ],
    input  logic [IDX_W-1:0] ptr,
    output logic             grant     [NUM_REQ],
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    // Scan ptr, ptr+1, ... modulo NUM_REQ and latch onto the first valid one.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = 1'b0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = IDX_W'((int'(ptr) + j) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/array_wr_arbiter.sv
// Round-robin arbiter serialising NUM_REQ writers into one shared register
// array through a single stage register, plus a registered read port with
// bypass of the write that is committing in the same cycle.
module array_wr_arbiter
    import array_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid [NUM_REQ],
    input  logic [ADDR_W-1:0] req_addr  [NUM_REQ],
    input  logic [WIDTH-1:0]  req_data  [NUM_REQ],
    output logic              req_ready [NUM_REQ],
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [IDX_W-1:0]  grant_id,
    output logic              oob_err,
    output logic [WIDTH-1:0]  mem_o     [DEPTH]
);

    logic              grant [NUM_REQ];
    logic              found;
    logic [IDX_W-1:0]  winner;
    logic              xfer;
    logic              in_range;

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              st_v_q, st_v_d;
    logic [ADDR_W-1:0] st_addr_q, st_addr_d;
    logic [WIDTH-1:0]  st_data_q, st_data_d;
    logic              oob_err_q, oob_err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .found     (found),
        .winner    (winner)
    );

    assign xfer     = found && !rst;
    assign in_range = (32'(req_addr[winner]) < 32'(DEPTH));

    // Ready follows the picker's one-hot grant, but nothing is accepted in reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant[i] && !rst;
        end
    end

    // Next state: pointer/grant advance on transfer, stage, commit and read.
    always_comb begin
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        if (xfer) begin
            ptr_d      = IDX_W'(next_ptr(32'(winner), NUM_REQ));
            grant_id_d = winner;
        end

        st_v_d    = xfer && in_range;
        st_addr_d = req_addr[winner];
        st_data_d = req_data[winner];
        oob_err_d = xfer && !in_range;

        mem_d = mem_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (st_v_q && st_addr_q == ADDR_W'(e)) begin
                mem_d[e] = st_data_q;
            end
        end

        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (rd_addr == ADDR_W'(e)) begin
                    rd_data_d = mem_q[e];
                end
            end
            if (st_v_q && st_addr_q == rd_addr) begin
                rd_data_d = st_data_q;
            end
        end
    end

    // All state registers; reset also drops any write still sitting in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            grant_id_q <= '0;
            st_v_q     <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= '0;
            oob_err_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            st_v_q     <= st_v_d;
            st_addr_q  <= st_addr_d;
            st_data_q  <= st_data_d;
            oob_err_q  <= oob_err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            mem_q      <= mem_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign grant_id = grant_id_q;
    assign oob_err  = oob_err_q;
    assign mem_o    = mem_q;

endmodule

// File: tb/tb_array_wr_arbiter.sv
// Scoreboard bench for array_wr_arbiter: stimulus pushes expected grants and
// read data, a negedge monitor pops and compares them. A second instance with
// DEPTH=3 exercises out-of-range writes and reads.
module tb_array_wr_arbiter;

    localparam int NR = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst;

    logic       req_valid [NR];
    logic [1:0] req_addr  [NR];
    logic [7:0] req_data  [NR];
    logic       req_ready [NR];
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [1:0] grant_id;
    logic       oob_err;
    logic [7:0] mem_o [DP];

    logic       d3_req_valid [NR];
    logic [1:0] d3_req_addr  [NR];
    logic [7:0] d3_req_data  [NR];
    logic       d3_req_ready [NR];
    logic       d3_rd_en;
    logic [1:0] d3_rd_addr;
    logic [7:0] d3_rd_data;
    logic       d3_rd_valid;
    logic [1:0] d3_grant_id;
    logic       d3_oob_err;
    logic [7:0] d3_mem_o [3];

    int vec_cnt = 0;
    int err_cnt = 0;
    int         exp_grant_q [$];
    logic [7:0] exp_rd_q    [$];

    array_wr_arbiter #(.NUM_REQ(NR), .DEPTH(DP), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .grant_id(grant_id), .oob_err(oob_err), .mem_o(mem_o)
    );

    array_wr_arbiter #(.NUM_REQ(NR), .DEPTH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(d3_req_valid), .req_addr(d3_req_addr), .req_data(d3_req_data),
        .req_ready(d3_req_ready),
        .rd_en(d3_rd_en), .rd_addr(d3_rd_addr), .rd_data(d3_rd_data), .rd_valid(d3_rd_valid),
        .grant_id(d3_grant_id), .oob_err(d3_oob_err), .mem_o(d3_mem_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkMem(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        checkOutput($sformatf("%s[0]", name), 32'(mem_o[0]), 32'(e0));
        checkOutput($sformatf("%s[1]", name), 32'(mem_o[1]), 32'(e1));
        checkOutput($sformatf("%s[2]", name), 32'(mem_o[2]), 32'(e2));
        checkOutput($sformatf("%s[3]", name), 32'(mem_o[3]), 32'(e3));
    endtask

    // Index of the single asserted ready; 15 when none, 14 when several.
    function automatic int readyIndex();
        int cnt;
        int idx;
        cnt = 0;
        idx = 15;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt > 1) ? 14 : idx;
    endfunction

    function automatic bit anyValid();
        bit v;
        v = 1'b0;
        for (int i = 0; i < NR; i++) begin
            v = v | req_valid[i];
        end
        return v;
    endfunction

    // Drive one cycle of requests/read, record expectations, then advance one edge.
    task automatic applyStimulus(input logic [3:0] vmask, input int exp_g, input logic rde,
                                 input logic [1:0] rda, input logic [7:0] exp_rd);
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = vmask[i];
        end
        rd_en   = rde;
        rd_addr = rda;
        if (vmask != 4'b0 && !rst) begin
            exp_grant_q.push_back(exp_g);
        end
        if (rde) begin
            exp_rd_q.push_back(exp_rd);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b0;
        end
        rd_en = 1'b0;
    endtask

    // Monitor: compare grants and read responses against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst && anyValid()) begin
            if (exp_grant_q.size() == 0) begin
                checkOutput("grant unexpected", 32'(readyIndex()), 32'd15);
            end else begin
                checkOutput("grant", 32'(readyIndex()), 32'(exp_grant_q.pop_front()));
            end
        end
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) begin
                checkOutput("rd_valid spurious", 32'(rd_valid), 32'd0);
            end else begin
                checkOutput("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        rd_en    = 1'b0;
        rd_addr  = '0;
        d3_rd_en = 1'b0;
        d3_rd_addr = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]    = 1'b0;
            req_addr[i]     = '0;
            req_data[i]     = '0;
            d3_req_valid[i] = 1'b0;
            d3_req_addr[i]  = '0;
            d3_req_data[i]  = '0;
        end

        // Reset: state cleared, ready held low even with every requester valid.
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b1;
        end
        #2;
        checkOutput("ready in reset", 32'(readyIndex()), 32'd15);
        checkMem("reset mem", 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset grant_id", 32'(grant_id), 32'd0);
        checkOutput("reset oob_err", 32'(oob_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'b0;
        end

        $display("[TB] idle read of address 2");
        applyStimulus(4'b0000, 0, 1'b1, 2'd2, 8'h00);

        $display("[TB] all requesters valid, rotating grants");
        for (int i = 0; i < NR; i++) begin
            req_addr[i] = 2'(i);
            req_data[i] = 8'hA0 + 8'(i);
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                checkOutput("rr mem[2] committed", 32'(mem_o[2]), 32'hA2);
                checkOutput("rr mem[3] not yet", 32'(mem_o[3]), 32'h00);
            end
            if (c == 5) begin
                checkMem("rr mem", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
            end
            applyStimulus(4'b1111, c % NR, 1'b0, 2'd0, 8'h00);
        end
        checkOutput("grant_id after rr", 32'(grant_id), 32'd3);

        $display("[TB] wrap-around from ptr=2");
        applyStimulus(4'b0010, 1, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b1010, 3, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b1010, 1, 1'b0, 2'd0, 8'h00);
        checkOutput("grant_id after wrap", 32'(grant_id), 32'd1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkMem("mid reset mem", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("[TB] read bypass of committing write");
        req_addr[0] = 2'd1;
        req_data[0] = 8'h5C;
        applyStimulus(4'b0001, 0, 1'b1, 2'd1, 8'h00);
        applyStimulus(4'b0000, 0, 1'b1, 2'd1, 8'h5C);
        checkOutput("mem[1] after commit", 32'(mem_o[1]), 32'h5C);
        applyStimulus(4'b0000, 0, 1'b1, 2'd1, 8'h5C);

        $display("[TB] back-to-back writes to one address");
        req_addr[0] = 2'd2;
        req_data[0] = 8'h11;
        req_addr[2] = 2'd2;
        req_data[2] = 8'h22;
        applyStimulus(4'b0001, 0, 1'b0, 2'd0, 8'h00);
        applyStimulus(4'b0100, 2, 1'b0, 2'd0, 8'h00);
        checkOutput("mem[2] first write", 32'(mem_o[2]), 32'h11);
        applyStimulus(4'b0000, 0, 1'b1, 2'd2, 8'h22);
        checkOutput("mem[2] later wins", 32'(mem_o[2]), 32'h22);

        $display("[TB] reset with a staged write");
        req_addr[0] = 2'd0;
        req_data[0] = 8'h77;
        applyStimulus(4'b0001, 0, 1'b0, 2'd0, 8'h00);
        rst = 1'b1;
        req_valid[0] = 1'b1;
        #2;
        checkOutput("ready forced low", 32'(readyIndex()), 32'd15);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid[0] = 1'b0;
        checkMem("post reset mem", 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("post reset rd_data", 32'(rd_data), 32'h00);
        @(posedge clk);
        #1;
        checkMem("staged write dropped", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("[TB] DEPTH=3 out-of-range write and read");
        d3_req_addr[0]  = 2'd3;
        d3_req_data[0]  = 8'h99;
        d3_req_valid[0] = 1'b1;
        #2;
        checkOutput("d3 oob ready", 32'(d3_req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        d3_req_valid[0] = 1'b0;
        checkOutput("d3 oob_err pulse", 32'(d3_oob_err), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("d3 oob_err clears", 32'(d3_oob_err), 32'd0);
        for (int e = 0; e < 3; e++) begin
            checkOutput($sformatf("d3 mem[%0d] unchanged", e), 32'(d3_mem_o[e]), 32'd0);
        end
        d3_req_addr[2]  = 2'd2;
        d3_req_data[2]  = 8'h42;
        d3_req_valid[2] = 1'b1;
        #2;
        checkOutput("d3 ready[2]", 32'(d3_req_ready[2]), 32'd1);
        @(posedge clk);
        #1;
        d3_req_valid[2] = 1'b0;
        checkOutput("d3 in-range no oob", 32'(d3_oob_err), 32'd0);
        checkOutput("d3 grant_id", 32'(d3_grant_id), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("d3 mem[2]", 32'(d3_mem_o[2]), 32'h42);
        d3_rd_en   = 1'b1;
        d3_rd_addr = 2'd2;
        @(posedge clk);
        #1;
        d3_rd_addr = 2'd3;
        checkOutput("d3 rd_valid", 32'(d3_rd_valid), 32'd1);
        checkOutput("d3 rd_data addr2", 32'(d3_rd_data), 32'h42);
        @(posedge clk);
        #1;
        d3_rd_en = 1'b0;
        checkOutput("d3 rd_data oob addr", 32'(d3_rd_data), 32'h00);

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("grant queue drained", 32'(exp_grant_q.size()), 32'd0);
        checkOutput("read queue drained", 32'(exp_rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
